// File: rtl/add_sub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package add_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A counter always needs at least one bit, even when there is a single digit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sub_digit.sv
// Combinational DIGIT-bit ripple slice built from per-bit full adders.
// c_msb is the carry into the slice's top bit, used for signed overflow.
module add_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_d[i]   = a_d[i] ^ b_d[i] ^ w_c[i];
    assign w_c[i+1] = (a_d[i] & b_d[i]) | (w_c[i] & (a_d[i] ^ b_d[i]));
  end

  assign c_out = w_c[DIGIT];
  assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first,
// start/busy/done handshake. Define ADDSUB_OVF_EN to build the signed-overflow flag.
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             x,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("add_sub_serial: DIGIT must be in 1..WIDTH and divide WIDTH");
  end

  state_e           r_state;
  state_e           w_state_next;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  int               w_base;
  logic [DIGIT-1:0] w_s_d;
  logic             w_c_out;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_res_next;

  // Subtraction is a + ~b + 1; the borrow-in folds into the inverted carry.
  assign w_b_eff = b ^ {WIDTH{x == MODE_SUB}};
  assign w_c0    = cin ^ (x == MODE_SUB);
  assign w_base  = int'(r_cnt) * DIGIT;

  add_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d   (r_a[w_base +: DIGIT]),
    .b_d   (r_b[w_base +: DIGIT]),
    .c_in  (r_carry),
    .s_d   (w_s_d),
    .c_out (w_c_out),
    .c_msb (w_c_msb)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (r_cnt == LAST) begin
          w_state_next = IDLE;
          w_last       = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_res_next                   = r_res;
    w_res_next[w_base +: DIGIT]  = w_s_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the working registers are cleared on reset too, so an aborted operation leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a     <= a;
        r_b     <= w_b_eff;
        r_carry <= w_c0;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_res   <= w_res_next;
        r_carry <= w_c_out;
        r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_c_out;
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_c_msb ^ w_c_out;
  end

  assign ovf = r_ovf;
`else
  logic w_unused_c_msb;
  assign w_unused_c_msb = w_c_msb;
  assign ovf            = 1'b0;
`endif

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial (WIDTH=8, DIGIT=4) plus DIGIT=1 and DIGIT=8 corner instances.
module tb_add_sub_serial;

  localparam int W = 8;
  localparam int N = 2;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         x, cin;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  logic         k_start;
  logic [W-1:0] k_a, k_b;
  logic         k_x, k_cin;
  logic         d1_busy, d1_done, d1_cout, d1_ovf;
  logic [W-1:0] d1_sum;
  logic         d8_busy, d8_done, d8_cout, d8_ovf;
  logic [W-1:0] d8_sum;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_run = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_sub_serial #(.WIDTH(W), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .x(x), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  add_sub_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(k_start), .a(k_a), .b(k_b), .x(k_x), .cin(k_cin),
    .busy(d1_busy), .done(d1_done), .sum(d1_sum), .cout(d1_cout), .ovf(d1_ovf)
  );

  add_sub_serial #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(k_start), .a(k_a), .b(k_b), .x(k_x), .cin(k_cin),
    .busy(d8_busy), .done(d8_done), .sum(d8_sum), .cout(d8_cout), .ovf(d8_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as written.
  function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                 input logic x_v, input logic cin_v, input int issue_cyc);
    exp_t m;
    int ua, ub, ci, sa, sb, r_u, r_s;
    ua = int'(a_v);
    ub = int'(b_v);
    ci = int'(cin_v);
    sa = int'($signed(a_v));
    sb = int'($signed(b_v));
    if (!x_v) begin
      r_u    = ua + ub + ci;
      r_s    = sa + sb + ci;
      m.cout = (r_u > 255);
    end else begin
      r_u    = ua - ub - ci;
      r_s    = sa - sb - ci;
      m.cout = (ua >= ub + ci);
    end
    m.sum = W'(r_u);
`ifdef ADDSUB_OVF_EN
    m.ovf = (r_s > 127) || (r_s < -128);
`else
    m.ovf = 1'b0;
`endif
    m.done_cyc = issue_cyc + N + 1;
    return m;
  endfunction

  // Monitor: compares every done against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum",        32'(sum),  32'(e.sum));
        check("cout",       32'(cout), 32'(e.cout));
        check("ovf",        32'(ovf),  32'(e.ovf));
        check("latency",    32'(cyc),  32'(e.done_cyc));
        check("busy_cycles", 32'(busy_run), 32'(N));
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Called at a negedge; waits for idle, pulses start for one cycle, leaves garbage on the inputs.
  task automatic issue(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input logic x_v, input logic cin_v);
    int guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("idle_timeout", 32'(busy), 32'd0);
    start = 1'b1; a = a_v; b = b_v; x = x_v; cin = cin_v;
    sb_q.push_back(model(a_v, b_v, x_v, cin_v, cyc));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); x = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic spurious_start();
    check("busy_during_op", 32'(busy), 32'd1);
    start = 1'b1;
    a = W'($urandom); b = W'($urandom); x = 1'($urandom); cin = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int t0, t1, t8;
    logic [W-1:0] s1, s8;
    logic c1, c8, o1, o8;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; x = 1'b0; cin = 1'b0;
    k_start = 1'b0; k_a = '0; k_b = '0; k_x = 1'b0; k_cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf",  32'(ovf),  32'd0);

    // Directed cases
    issue(8'h3A, 8'h15, 1'b0, 1'b0);
    issue(8'h10, 8'h01, 1'b1, 1'b0);
    issue(8'h01, 8'h02, 1'b1, 1'b0);
    issue(8'h05, 8'h02, 1'b1, 1'b1);
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    issue(8'h80, 8'h01, 1'b1, 1'b0);
    issue(8'h10, 8'h01, 1'b0, 1'b0);
    drain();

    // start while busy is ignored; back-to-back issue lands in the done cycle
    issue(8'hC3, 8'h5A, 1'b0, 1'b1);
    spurious_start();
    issue(8'h44, 8'h99, 1'b1, 1'b0);
    drain();

    // Reset after E1 aborts the operation
    issue(8'h21, 8'h43, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    repeat (6) @(negedge clk);
    issue(8'hE7, 8'h2C, 1'b0, 1'b1);
    drain();

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) spurious_start();
    end
    drain();

    // Parameter corners: DIGIT=1 (N=8) and DIGIT=8 (N=1)
    k_start = 1'b1; k_a = 8'hFF; k_b = 8'h01; k_x = 1'b0; k_cin = 1'b1;
    t0 = cyc; t1 = -1; t8 = -1;
    s1 = '0; s8 = '0; c1 = 1'b0; c8 = 1'b0; o1 = 1'b1; o8 = 1'b1;
    @(negedge clk);
    k_start = 1'b0; k_a = W'($urandom); k_b = W'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (d1_done && t1 < 0) begin t1 = cyc; s1 = d1_sum; c1 = d1_cout; o1 = d1_ovf; end
      if (d8_done && t8 < 0) begin t8 = cyc; s8 = d8_sum; c8 = d8_cout; o8 = d8_ovf; end
      @(negedge clk);
    end
    check("d1_latency", 32'(t1 - t0), 32'd9);
    check("d1_sum",     32'(s1), 32'h01);
    check("d1_cout",    32'(c1), 32'd1);
    check("d1_ovf",     32'(o1), 32'd0);
    check("d8_latency", 32'(t8 - t0), 32'd2);
    check("d8_sum",     32'(s8), 32'h01);
    check("d8_cout",    32'(c8), 32'd1);
    check("d8_ovf",     32'(o8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised digit-serial adder/subtractor, the multi-cycle successor to the 1-bit `add_sub` cell. It accepts WIDTH-bit operands with a start pulse and processes DIGIT bits per clock, LSB digit first, through a DIGIT-bit ripple slice. It reports the result with a one-cycle done pulse. It sits in the datapath wherever a narrow, area-cheap add/sub with start/busy/done control is needed instead of a full-width combinational adder.

## Interface
- `WIDTH`, default 16: operand and result width in bits.
- `DIGIT`, default 4: bits processed per cycle.
  - Must satisfy 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0; otherwise elaboration fails.
  - N = WIDTH/DIGIT.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  operation request; sampled only when not busy.
- `a`  in  WIDTH  operand A; sampled with start.
- `b`  in  WIDTH  operand B; sampled with start.
- `x`  in  1  mode: 0 = add, 1 = subtract; sampled with start.
- `cin`  in  1  carry-in (add) or borrow-in (subtract); sampled with start.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; sum, cout and ovf are valid.
- `sum`  out  WIDTH  result; held until the next done.
- `cout`  out  1  carry-out of the MSB. In subtract mode, 1 means no borrow.
- `ovf`  out  1  signed overflow (see Configuration).

## Operation
- Effective operands: `b_eff = b ^ {WIDTH{x}}`, initial carry `c0 = cin ^ x`.
  - x=0: sum = a + b + cin.
  - x=1: sum = a − b − cin.
  - All arithmetic is mod 2^WIDTH; cout is bit WIDTH of `a + b_eff + c0`.
- FSM states:
  - IDLE: waiting for start. `start=1` latches a, b_eff and c0, clears digit counter `cnt`, and moves to RUN.
  - RUN: each edge adds digit `cnt` (bits `cnt*DIGIT +: DIGIT`) with the stored carry, writes that digit of the result register, updates the carry, and increments `cnt`.
  - When `cnt == N−1`: load sum/cout/ovf, pulse done, return to IDLE.
- `start` while busy: ignored; operands are not resampled.
- Input changes on a, b, x, cin while busy: no effect.
- `sum`/`cout`/`ovf` update only at the completing edge. No partial results are visible on the outputs.

## Timing
- Edge E0 samples start. Edges E1..EN each consume one digit.
- `busy` is 1 in the cycles after E0 up to and including the cycle before EN.
- After EN: busy=0, done=1 for exactly one cycle, and outputs are valid.
- Latency: done is visible N+1 cycles after the start cycle.
- start asserted in the done cycle is accepted at E(N+1). Back-to-back throughput is one operation per N+1 cycles.
- DIGIT == WIDTH gives N=1: done appears 2 cycles after start.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, cnt=0.
- rst mid-operation: abort at that edge; no done is produced and outputs return to their reset values.
- rst and start in the same cycle: rst wins and start is dropped.

## Configuration
- `ADDSUB_OVF_EN` defined:
  - Track the carry into the MSB, c_msb.
  - At completion, `ovf = c_msb ^ cout` (two's-complement overflow of the effective addition).
  - ovf is valid only with done and is held like sum.
- `ADDSUB_OVF_EN` undefined:
  - No overflow logic is built.
  - The `ovf` port remains and is tied to 0, so the interface is identical in both builds.

## Structure
- Package `add_sub_pkg`:
  - State enum {IDLE, RUN}.
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module `add_sub_digit`: combinational DIGIT-bit ripple slice.
  - Inputs: a_d, b_d (already inverted), c_in.
  - Outputs: s_d, c_out, c_msb.
  - Built from per-bit full-adder equations.
- Top level owns the FSM, digit counter, operand and result registers, carry register, and the done pulse.

## Test plan
Default configuration for all scenarios: WIDTH=8, DIGIT=4 (N=2).
- **Basic add:** add, a=8'h3A, b=8'h15, cin=0 → sum=8'h4F, cout=0. done 3 cycles after the start cycle; busy high for 2 cycles.
- **Subtract:**
  - x=1, a=8'h10, b=8'h01, cin=0 → sum=8'h0F, cout=1.
  - x=1, a=8'h01, b=8'h02 → sum=8'hFF, cout=0.
  - x=1, cin=1, a=8'h05, b=8'h02 → sum=8'h02.
- **Overflow:**
  - 8'h7F + 8'h01 → sum=8'h80, ovf=1 with `ADDSUB_OVF_EN` (0 without).
  - Subtract 8'h80 − 8'h01 → sum=8'h7F, ovf=1 with the macro.
  - 8'h10 + 8'h01 → ovf=0.
- **Handshake:**
  - start pulsed again while busy with different operands → ignored; the first result is delivered.
  - start held in the done cycle → second operation accepted; second done arrives 3 cycles later.
- **Reset mid-operation:** rst asserted after E1 of an add → busy=0, done never pulses, sum=0, cout=0. A following start completes normally.
- **Parameter corners:**
  - DIGIT=1 (N=8), 8'hFF + 8'h01, cin=1 → sum=8'h01, cout=1, done 9 cycles after start.
  - DIGIT=8 (N=1), same operands → same result, done 2 cycles after start.
